// File: rtl/xbox_xlr_matmul_nxn.sv
// rtl/xbox_xlr_matmul_nxn.sv - DIM x DIM signed integer matmul, C = A*B, A/C in MEM0, B in MEM1.
// One matrix row per memory line; the host programs bases over the CSR file and polls DONE/CYCLES.
module xbox_xlr_matmul_nxn #(
   parameter int NUM_MEMS           = 2,
   parameter int LOG2_LINES_PER_MEM = 8,
   parameter int DIM                = 4
) (
   input  logic                                          clk,
   input  logic                                          rst_n,
   output logic [NUM_MEMS-1:0][LOG2_LINES_PER_MEM-1:0]   xlr_mem_addr,
   output logic [NUM_MEMS-1:0][7:0][31:0]                xlr_mem_wdata,
   output logic [NUM_MEMS-1:0][31:0]                     xlr_mem_be,
   output logic [NUM_MEMS-1:0]                           xlr_mem_rd,
   output logic [NUM_MEMS-1:0]                           xlr_mem_wr,
   input  logic [NUM_MEMS-1:0][7:0][31:0]                xlr_mem_rdata,
   input  logic [31:0][31:0]                             host_regs,
   input  logic [31:0]                                   host_regs_valid_pulse,
   output logic [31:0][31:0]                             host_regs_data_out,
   output logic [31:0]                                   host_regs_valid_out
);

   localparam int LW = LOG2_LINES_PER_MEM;
   typedef logic [LW-1:0] addr_t;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_B, S_RD_A, S_CAP_A, S_MAC, S_WR_C, S_DONE
   } state_t;

   state_t      state;
   logic        start_q;
   logic        busy;
   logic        done;
   logic [31:0] cycles;
   addr_t       a_base;
   addr_t       b_base;
   addr_t       c_base;
   logic [3:0]  t;
   logic [3:0]  t_prev;
   logic [2:0]  i;
   logic [2:0]  k;
   logic [31:0] b_buf   [8][8];
   logic [31:0] a_row   [8];
   logic [31:0] acc     [8];
   logic [31:0] acc_sum [8];
   logic        unused_bits;

   assign t_prev      = t - 4'd1;
   assign unused_bits = ^{host_regs, host_regs_valid_pulse, xlr_mem_rdata};

   // One MAC step for all columns; product and sum wrap mod 2^32.
   always_comb begin
      for (int j = 0; j < 8; j++) begin
         acc_sum[j] = acc[j] + a_row[k] * b_buf[k][j];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state               <= S_IDLE;
         start_q             <= 1'b0;
         busy                <= 1'b0;
         done                <= 1'b0;
         cycles              <= '0;
         a_base              <= '0;
         b_base              <= '0;
         c_base              <= '0;
         t                   <= '0;
         i                   <= '0;
         k                   <= '0;
         xlr_mem_addr        <= '0;
         xlr_mem_wdata       <= '0;
         xlr_mem_be          <= '0;
         xlr_mem_rd          <= '0;
         xlr_mem_wr          <= '0;
         host_regs_data_out  <= '0;
         host_regs_valid_out <= '0;
         for (int r = 0; r < 8; r++) begin
            a_row[r] <= '0;
            acc[r]   <= '0;
            for (int c = 0; c < 8; c++) begin
               b_buf[r][c] <= '0;
            end
         end
      end else begin
         start_q    <= host_regs_valid_pulse[0] && (host_regs[0] == 32'd1);
         xlr_mem_rd <= '0;
         xlr_mem_wr <= '0;

         host_regs_data_out     <= '0;
         host_regs_data_out[1]  <= {31'd0, busy};
         host_regs_data_out[2]  <= {31'd0, done};
         host_regs_data_out[6]  <= cycles;
         host_regs_valid_out    <= '0;
         host_regs_valid_out[1] <= 1'b1;
         host_regs_valid_out[2] <= done;
         host_regs_valid_out[6] <= 1'b1;

         if (state != S_IDLE && state != S_DONE) begin
            cycles <= cycles + 32'd1;
         end

         case (state)
            S_IDLE: begin
               if (start_q) begin
                  busy            <= 1'b1;
                  done            <= 1'b0;
                  cycles          <= '0;
                  a_base          <= host_regs[3][LW-1:0];
                  b_base          <= host_regs[4][LW-1:0];
                  c_base          <= host_regs[5][LW-1:0];
                  t               <= '0;
                  i               <= '0;
                  xlr_mem_rd[1]   <= 1'b1;
                  xlr_mem_addr[1] <= host_regs[4][LW-1:0];
                  state           <= S_LOAD_B;
               end
            end
            S_LOAD_B: begin
               // Reads are issued in cycles 0..DIM-1, data lands one cycle later.
               if (t != 4'd0) begin
                  for (int j = 0; j < DIM; j++) begin
                     b_buf[t_prev[2:0]][j] <= xlr_mem_rdata[1][j];
                  end
               end
               if (int'(t) < DIM - 1) begin
                  xlr_mem_rd[1]   <= 1'b1;
                  xlr_mem_addr[1] <= b_base + addr_t'(t) + addr_t'(1);
               end
               if (int'(t) == DIM) begin
                  xlr_mem_rd[0]   <= 1'b1;
                  xlr_mem_addr[0] <= a_base;
                  state           <= S_RD_A;
               end else begin
                  t <= t + 4'd1;
               end
            end
            S_RD_A: begin
               state <= S_CAP_A;
            end
            S_CAP_A: begin
               for (int j = 0; j < 8; j++) begin
                  acc[j] <= '0;
               end
               for (int j = 0; j < DIM; j++) begin
                  a_row[j] <= xlr_mem_rdata[0][j];
               end
               k     <= '0;
               state <= S_MAC;
            end
            S_MAC: begin
               for (int j = 0; j < 8; j++) begin
                  acc[j] <= acc_sum[j];
               end
               if (int'(k) == DIM - 1) begin
                  xlr_mem_wr[0]   <= 1'b1;
                  xlr_mem_addr[0] <= c_base + addr_t'(i);
                  xlr_mem_be[0]   <= '1;
                  for (int j = 0; j < 8; j++) begin
                     xlr_mem_wdata[0][j] <= (j < DIM) ? acc_sum[j] : 32'd0;
                  end
                  state <= S_WR_C;
               end else begin
                  k <= k + 3'd1;
               end
            end
            S_WR_C: begin
               xlr_mem_be[0]    <= '0;
               xlr_mem_wdata[0] <= '0;
               if (int'(i) < DIM - 1) begin
                  i               <= i + 3'd1;
                  xlr_mem_rd[0]   <= 1'b1;
                  xlr_mem_addr[0] <= a_base + addr_t'(i) + addr_t'(1);
                  state           <= S_RD_A;
               end else begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_xbox_xlr_matmul_nxn.sv
// tb/tb_xbox_xlr_matmul_nxn.sv - randomized self-checking bench for xbox_xlr_matmul_nxn.
// Three instances (DIM 2, 4, 1) share one clock; an event-queue model checks every memory strobe.
module tb_xbox_xlr_matmul_nxn;

   typedef struct {
      logic         wr;
      logic [7:0]   addr;
      logic [255:0] data;
   } ev_t;

   logic                    clk;
   logic                    rst_n;
   logic [31:0][31:0]       host_regs;
   logic [31:0]             vpulse  [3];
   logic [1:0][7:0]         m_addr  [3];
   logic [1:0][7:0][31:0]   m_wdata [3];
   logic [1:0][31:0]        m_be    [3];
   logic [1:0]              m_rd    [3];
   logic [1:0]              m_wr    [3];
   logic [1:0][7:0][31:0]   m_rdata [3];
   logic [31:0][31:0]       h_out   [3];
   logic [31:0]             h_vout  [3];

   logic [255:0] mem  [3][2][256];
   logic [255:0] wtmp;
   logic [255:0] ltmp;
   logic [31:0]  ma   [8][8];
   logic [31:0]  mb   [8][8];
   logic [255:0] cexp [8];
   logic [7:0]   run_cb;
   ev_t          q0[$];
   logic [7:0]   q1[$];
   int           cur;
   int           total;
   int           bad;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      xbox_xlr_matmul_nxn #(
         .NUM_MEMS(2),
         .LOG2_LINES_PER_MEM(8),
         .DIM(g == 0 ? 2 : (g == 1 ? 4 : 1))
      ) u_dut (
         .clk(clk),
         .rst_n(rst_n),
         .xlr_mem_addr(m_addr[g]),
         .xlr_mem_wdata(m_wdata[g]),
         .xlr_mem_be(m_be[g]),
         .xlr_mem_rd(m_rd[g]),
         .xlr_mem_wr(m_wr[g]),
         .xlr_mem_rdata(m_rdata[g]),
         .host_regs(host_regs),
         .host_regs_valid_pulse(vpulse[g]),
         .host_regs_data_out(h_out[g]),
         .host_regs_valid_out(h_vout[g])
      );
   end

   always #5 clk = ~clk;

   function automatic int dim_of(input int g);
      return (g == 0) ? 2 : ((g == 1) ? 4 : 1);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chkw(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Memory model: read data appears the cycle after rd, writes honour byte enables.
   always @(posedge clk) begin
      for (int g = 0; g < 3; g++) begin
         for (int m = 0; m < 2; m++) begin
            if (m_rd[g][m]) m_rdata[g][m] <= mem[g][m][m_addr[g][m]];
            if (m_wr[g][m]) begin
               wtmp = m_wdata[g][m];
               ltmp = mem[g][m][m_addr[g][m]];
               for (int b = 0; b < 32; b++) begin
                  if (m_be[g][m][b]) ltmp[8*b +: 8] = wtmp[8*b +: 8];
               end
               mem[g][m][m_addr[g][m]] = ltmp;
            end
         end
      end
   end

   // Every strobe must match the next expected memory operation of the active instance.
   always @(negedge clk) begin
      ev_t        e;
      logic [7:0] a;
      for (int g = 0; g < 3; g++) begin
         if (m_rd[g][1] || m_wr[g][1]) begin
            if (g == cur && !m_wr[g][1] && q1.size() > 0) begin
               a = q1.pop_front();
               chk("b_rd_addr", 32'(m_addr[g][1]), 32'(a));
            end else begin
               chk("mem1_unexpected", 32'({m_wr[g][1], m_rd[g][1]}), 32'd0);
            end
         end
         if (m_rd[g][0] || m_wr[g][0]) begin
            if (g == cur && q0.size() > 0) begin
               e = q0.pop_front();
               chk("mem0_rdwr_excl", 32'(m_rd[g][0] & m_wr[g][0]), 32'd0);
               chk("mem0_kind", 32'(m_wr[g][0]), 32'(e.wr));
               chk("mem0_addr", 32'(m_addr[g][0]), 32'(e.addr));
               if (e.wr) begin
                  chk("c_be", m_be[g][0], 32'hFFFF_FFFF);
                  chkw("c_wdata", m_wdata[g][0], e.data);
               end
            end else begin
               chk("mem0_unexpected", 32'({m_wr[g][0], m_rd[g][0]}), 32'd0);
            end
         end
      end
   end

   task automatic start(input int g);
      vpulse[g][0] = 1'b1;
      host_regs[0] = 32'd1;
      cyc(1);
      vpulse[g][0] = 1'b0;
      host_regs[0] = 32'd0;
   endtask

   task automatic rand_mats(input int dim);
      for (int r = 0; r < dim; r++) begin
         for (int c = 0; c < dim; c++) begin
            ma[r][c] = $urandom();
            mb[r][c] = $urandom();
         end
      end
   endtask

   // Loads A/B, builds the expected C and operation order, then starts the instance.
   task automatic prepare(input int g, input logic [7:0] ab, input logic [7:0] bb, input logic [7:0] cb);
      int           dim;
      logic [255:0] line;
      logic [31:0]  s;
      ev_t          e;
      dim = dim_of(g);
      q0.delete();
      q1.delete();
      for (int r = 0; r < dim; r++) begin
         for (int w = 0; w < 8; w++) line[32*w +: 32] = $urandom();
         for (int c = 0; c < dim; c++) line[32*c +: 32] = ma[r][c];
         mem[g][0][ab + 8'(r)] = line;
         for (int w = 0; w < 8; w++) line[32*w +: 32] = $urandom();
         for (int c = 0; c < dim; c++) line[32*c +: 32] = mb[r][c];
         mem[g][1][bb + 8'(r)] = line;
         q1.push_back(bb + 8'(r));
      end
      for (int r = 0; r < dim; r++) begin
         cexp[r] = '0;
         for (int c = 0; c < dim; c++) begin
            s = '0;
            for (int x = 0; x < dim; x++) s = s + ma[r][x] * mb[x][c];
            cexp[r][32*c +: 32] = s;
         end
         e.wr = 1'b0; e.addr = ab + 8'(r); e.data = '0;
         q0.push_back(e);
         e.wr = 1'b1; e.addr = cb + 8'(r); e.data = cexp[r];
         q0.push_back(e);
      end
      run_cb       = cb;
      host_regs[3] = {24'($urandom()), ab};
      host_regs[4] = {24'($urandom()), bb};
      host_regs[5] = {24'($urandom()), cb};
      cur          = g;
      start(g);
      cyc(3);
      chk("busy_during_run", h_out[g][1], 32'd1);
      chk("done_cleared", h_out[g][2], 32'd0);
   endtask

   task automatic finish_run(input int g);
      int dim;
      int n;
      dim = dim_of(g);
      n   = 0;
      while (h_out[g][2] != 32'd1 && n < 300) begin
         cyc(1);
         n++;
      end
      if (n >= 300) chk("done_timeout", h_out[g][2], 32'd1);
      chk("cycles", h_out[g][6], 32'((dim + 1) + dim * (dim + 3)));
      chk("busy_end", h_out[g][1], 32'd0);
      chk("valid_bits", h_vout[g], 32'h0000_0046);
      chk("q0_left", 32'(q0.size()), 32'd0);
      chk("q1_left", 32'(q1.size()), 32'd0);
      for (int r = 0; r < dim; r++) chkw("c_mem_row", mem[g][0][run_cb + 8'(r)], cexp[r]);
   endtask

   task automatic chk_reset_outputs(input string name);
      for (int g = 0; g < 3; g++) begin
         chk(name, 32'(|{m_addr[g], m_wdata[g], m_be[g], m_rd[g], m_wr[g], h_out[g], h_vout[g]}), 32'd0);
      end
   endtask

   initial begin
      clk       = 1'b0;
      rst_n     = 1'b0;
      host_regs = '0;
      for (int g = 0; g < 3; g++) vpulse[g] = '0;
      cur   = -1;
      total = 0;
      bad   = 0;

      cyc(2);
      chk_reset_outputs("reset_outputs_zero");
      rst_n = 1'b1;
      cyc(1);
      for (int g = 0; g < 3; g++) begin
         chk("idle_valid", h_vout[g], 32'h0000_0042);
         chk("idle_cycles", h_out[g][6], 32'd0);
      end

      // 2x2 reference example
      ma[0][0] = 32'd1; ma[0][1] = 32'd2; ma[1][0] = 32'd3; ma[1][1] = 32'd4;
      mb[0][0] = 32'd5; mb[0][1] = 32'd6; mb[1][0] = 32'd7; mb[1][1] = 32'd8;
      prepare(0, 8'h00, 8'h00, 8'h10);
      finish_run(0);
      chk("c00", mem[0][0][8'h10][31:0], 32'd19);
      chk("c01", mem[0][0][8'h10][63:32], 32'd22);
      chk("c02_zero", mem[0][0][8'h10][95:64], 32'd0);
      chk("c10", mem[0][0][8'h11][31:0], 32'd43);
      chk("c11", mem[0][0][8'h11][63:32], 32'd50);
      chk("cycles_dim2", h_out[0][6], 32'd13);

      // 4x4 in place with identity B
      rand_mats(4);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) mb[r][c] = (r == c) ? 32'd1 : 32'd0;
      ma[0][0] = 32'hFFFF_FFFF; ma[0][1] = 32'd2; ma[0][2] = 32'd0; ma[0][3] = 32'd0;
      prepare(1, 8'h20, 8'h30, 8'h20);
      finish_run(1);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) chk("inplace_eq_a", mem[1][0][8'h20 + 8'(r)][32*c +: 32], ma[r][c]);
      chk("inplace_neg1", mem[1][0][8'h20][31:0], 32'hFFFF_FFFF);
      chk("cycles_dim4", h_out[1][6], 32'd33);

      // 1x1 wrapping overflow
      ma[0][0] = 32'h7FFF_FFFF;
      mb[0][0] = 32'd2;
      prepare(2, 8'h05, 8'h09, 8'h06);
      finish_run(2);
      chk("overflow_wrap", mem[2][0][8'h06][31:0], 32'hFFFF_FFFE);

      // address wrap at the top of the line space
      rand_mats(2);
      prepare(0, 8'hFF, 8'hFF, 8'hFF);
      finish_run(0);

      // START during MAC with different bases must be ignored
      rand_mats(4);
      prepare(1, 8'h40, 8'h50, 8'h80);
      cyc(6);
      host_regs[3] = 32'h99; host_regs[4] = 32'hAA; host_regs[5] = 32'hBB;
      start(1);
      finish_run(1);
      cyc(20);
      chk("no_restart_q0", 32'(q0.size()), 32'd0);
      chk("done_sticky", h_out[1][2], 32'd1);
      chk("done_sticky_valid", 32'(h_vout[1][2]), 32'd1);
      chk("cycles_hold", h_out[1][6], 32'd33);

      // reset in the middle of MAC, then a fresh run
      rand_mats(4);
      prepare(1, 8'h60, 8'h70, 8'hA0);
      cyc(6);
      rst_n = 1'b0;
      cyc(1);
      chk_reset_outputs("midrun_reset_zero");
      rst_n = 1'b1;
      q0.delete();
      q1.delete();
      cyc(20);
      chk("abort_no_done", h_out[1][2], 32'd0);
      chk("abort_not_busy", h_out[1][1], 32'd0);
      rand_mats(4);
      prepare(1, 8'h10, 8'h20, 8'hC0);
      finish_run(1);

      // random runs across all instances
      for (int rep = 0; rep < 6; rep++) begin
         logic [7:0] ab;
         ab = 8'($urandom());
         rand_mats(dim_of(rep % 3));
         prepare(rep % 3, ab, 8'($urandom()), ab + 8'h80);
         finish_run(rep % 3);
      end

      cur = -1;
      cyc(5);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/xbox_xlr_matmul_nxn.md
Name: xbox_xlr_matmul_nxn

Overview:
Parametrised signed integer matrix-multiply accelerator, C = A*B, with DIM x DIM matrices, in the XBOX accelerator slot. It is driven by the host over the CSR register file. A rows are read from MEM0 and B rows from MEM1, and C rows are written back to MEM0. It is the successor to the fixed 2x2 single-line matmul and adds configurable dimension, software-programmed base addresses, a multi-line row-per-line layout, a sticky DONE and a cycle counter.

Parameters:
NUM_MEMS, 2, number of XBOX memory instances (must be >=2; MEM0 holds A and C, MEM1 holds B).
LOG2_LINES_PER_MEM, 8, address width per memory.
DIM, 4, matrix dimension, legal range 1..8; row r of a matrix occupies one line, element k in word k.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
xlr_mem_addr  out  [NUM_MEMS][LOG2_LINES_PER_MEM]  line address per memory.
xlr_mem_wdata  out  [NUM_MEMS][8][32]  write data per memory.
xlr_mem_be  out  [NUM_MEMS][32]  byte enables.
xlr_mem_rd  out  [NUM_MEMS]  read strobe.
xlr_mem_wr  out  [NUM_MEMS]  write strobe.
xlr_mem_rdata  in  [NUM_MEMS][8][32]  read data, valid the cycle after rd.
host_regs  in  [32][32]  host-written register contents.
host_regs_valid_pulse  in  32  one-cycle host write pulse per register.
host_regs_data_out  out  [32][32]  registers returned to software.
host_regs_valid_out  out  32  per-register valid for data_out.

Behaviour:
- CSR map:
  - reg0 START: start when the written value is 1 and valid_pulse[0] is set.
  - reg1 BUSY (RO).
  - reg2 DONE (RO, sticky).
  - reg3 A_BASE, reg4 B_BASE, reg5 C_BASE (low LOG2 bits used).
  - reg6 CYCLES (RO).
- Reset (rst_n=0 at a clk edge) drives all of the following to zero and sets state to IDLE:
  - mem outputs (addr, wdata, be, rd, wr);
  - host_regs_data_out and host_regs_valid_out;
  - B buffer, accumulators, counters.
- Reset asserted mid-operation aborts immediately; no further memory writes occur.
- START goes through a one-cycle front-door register. Base registers are latched at the cycle the sampled start is seen in IDLE.
- START while BUSY is ignored (no restart, no relatch).
- FSM states: IDLE, LOAD_B, RD_A, CAP_A, MAC, WR_C, DONE.
  - IDLE: waits for start. On start: BUSY=1, clear DONE and CYCLES, go to LOAD_B.
  - LOAD_B (DIM+1 cycles):
    - In cycles 0..DIM-1, rd[MEM1]=1 with addr B_BASE+t.
    - In cycles 1..DIM, rdata[MEM1] words [DIM-1:0] are captured into B buffer row t-1.
  - RD_A (1 cycle): rd[MEM0]=1, addr=A_BASE+i.
  - CAP_A (1 cycle): A row captured; accumulators cleared; k=0.
  - MAC (DIM cycles): for every j<DIM in parallel, acc[j] += A[i][k]*B[k][j]; k increments each cycle.
  - WR_C (1 cycle): on MEM0, wr=1, addr=C_BASE+i, be=all ones.
    - wdata words [DIM-1:0]=acc; words [7:DIM]=0.
    - If i<DIM-1, i++ and go to RD_A; else go to DONE.
  - DONE (1 cycle): BUSY=0, DONE=1, return to IDLE.
- Busy-cycle count is (DIM+1)+DIM*(DIM+3): 13 for DIM=2, 33 for DIM=4. CYCLES holds this count at DONE.
- Arithmetic: signed 32x32 multiply and 32-bit accumulate, truncated and wrapping mod 2^32. No saturation and no overflow flag.
- Address arithmetic wraps mod 2^LOG2_LINES_PER_MEM.
- C_BASE==A_BASE (in-place) is legal because row i is written only after A row i is captured. Other overlaps of C with unread A rows are software error; the result is undefined.
- All rd/wr strobes are zero outside the states listed. No memory other than MEM0/MEM1 is ever strobed.
- host_regs_data_out is registered, one cycle after the internal state.
- valid_out is always 1 for BUSY and CYCLES, and is 1 for DONE while DONE=1.
- DONE stays 1 until the next accepted start.

Test Plan:
- DIM=2, A=[[1,2],[3,4]] at line 0x00, B=[[5,6],[7,8]] at MEM1 0x00, C_BASE=0x10, START -> MEM0 line 0x10 words0..1 = 19,22; line 0x11 = 43,50; words 2..7 = 0; DONE=1, CYCLES=13.
- DIM=4, A=[[-1,2,0,0],...], B=identity, C_BASE=A_BASE -> C equals A in place, including 0xFFFFFFFF for -1; CYCLES=33.
- Overflow: DIM=1, A=0x7FFFFFFF, B=2 -> C=0xFFFFFFFE; no error flag raised.
- Address wrap: DIM=2, A_BASE=0xFF -> A read addresses 0xFF then 0x00; C_BASE=0xFF -> writes at 0xFF, 0x00.
- START pulsed again during MAC -> ignored; exactly DIM writes occur; base registers are not relatched.
- rst_n=0 for one cycle during MAC, then START with new bases -> no WR_C from the aborted run; all outputs zero during reset; the fresh run completes with correct C.
